// File: rtl/traffic_inject_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_inject_ctrl
//
// Per-core injection scheduler for the synthetic traffic bench. A percent
// credit accumulator paces packet starts at INJ_RATE percent of cycles. Each
// packet runs IDLE -> GEN (one-cycle gen_en pulse to the destination/class
// generators) -> CHECK (generator outputs sampled) -> SEND (valid/ready hand-
// off to the NI), or back to IDLE from CHECK when the generator reports an
// invalid destination. After MAX_PCK_NUM packets (sent + skipped) the block
// parks in DONE until reset.
//
// Optional feature macro: TRAFFIC_INJ_STALL_CNT_EN
//   defined     : stall_cnt counts SEND cycles with req_ready=0 (saturating)
//   not defined : stall_cnt is tied to 0, no counter logic
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           level; injection permitted while high
//   core_num        core index (routed to the generators by the top level)
//   gen_en          one-cycle enable pulse to the generators
//   pck_number      current packet index, fed to the generators
//   dest_x/dest_y   generator destination
//   valid_dst       generator destination-valid flag
//   pck_class_in    generator packet class
//   req_valid       registered packet request to the NI
//   req_ready       NI accepts the request
//   req_dest_x/y    latched destination
//   req_class       latched packet class
//   sent_cnt        packets accepted by the NI
//   skip_cnt        packets discarded because valid_dst was 0
//   stall_cnt       SEND cycles with req_ready=0 (optional feature)
//   done            all packets processed
// ---------------------------------------------------------------------------
module traffic_inject_ctrl #(
    parameter int  NX          = 4,
    parameter int  NY          = 4,
    parameter int  C           = 4,
    parameter int  MAX_PCK_NUM = 10000,
    parameter int  INJ_RATE    = 20,
    localparam int Xw          = (NX > 1) ? $clog2(NX) : 1,
    localparam int Yw          = (NY > 1) ? $clog2(NY) : 1,
    localparam int Cw          = (C > 1) ? $clog2(C) : 1,
    localparam int NCw         = (NX * NY > 1) ? $clog2(NX * NY) : 1,
    localparam int PCK_CNTw    = $clog2(MAX_PCK_NUM + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NCw-1:0]      core_num,
    output logic                gen_en,
    output logic [PCK_CNTw-1:0] pck_number,
    input  logic [Xw-1:0]       dest_x,
    input  logic [Yw-1:0]       dest_y,
    input  logic                valid_dst,
    input  logic [Cw-1:0]       pck_class_in,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [Xw-1:0]       req_dest_x,
    output logic [Yw-1:0]       req_dest_y,
    output logic [Cw-1:0]       req_class,
    output logic [PCK_CNTw-1:0] sent_cnt,
    output logic [PCK_CNTw-1:0] skip_cnt,
    output logic [31:0]         stall_cnt,
    output logic                done
);

    localparam int                  ACCw     = $clog2(200);
    localparam logic [ACCw-1:0]     ACC_100  = ACCw'(100);
    localparam logic [ACCw-1:0]     ACC_RATE = ACCw'(INJ_RATE);
    localparam logic [PCK_CNTw-1:0] PCK_MAX  = PCK_CNTw'(MAX_PCK_NUM);
    localparam logic [PCK_CNTw-1:0] PCK_ONE  = PCK_CNTw'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_CHECK,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ACCw-1:0]     acc_q, acc_d;
    logic [PCK_CNTw-1:0] pck_number_q, pck_number_d;
    logic [PCK_CNTw-1:0] sent_cnt_q, sent_cnt_d;
    logic [PCK_CNTw-1:0] skip_cnt_q, skip_cnt_d;
    logic [Xw-1:0]       req_dest_x_q, req_dest_x_d;
    logic [Yw-1:0]       req_dest_y_q, req_dest_y_d;
    logic [Cw-1:0]       req_class_q, req_class_d;
    logic                req_valid_q, req_valid_d;
    logic                done_q, done_d;
    logic                token;

    // The core index only travels to the generators at the top level.
    logic unused_core_num;
    assign unused_core_num = ^core_num;

    // acc >= 100 means one packet's worth of credit is banked.
    assign token = (acc_q >= ACC_100);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave it unassigned and infer a latch.
        state_d      = state_q;
        acc_d        = acc_q;
        pck_number_d = pck_number_q;
        sent_cnt_d   = sent_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        req_dest_x_d = req_dest_x_q;
        req_dest_y_d = req_dest_y_q;
        req_class_d  = req_class_q;
        req_valid_d  = req_valid_q;

        // Credit accrues only while no token is banked, so acc tops out at 199.
        if (start && (state_q != S_DONE) && !token) begin
            acc_d = acc_q + ACC_RATE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pck_number_q == PCK_MAX) begin
                    state_d = S_DONE;
                end else if (start && token) begin
                    // Consume the token; this cycle's credit still counts.
                    state_d = S_GEN;
                    acc_d   = acc_q - ACC_100 + ACC_RATE;
                end
            end
            S_GEN: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Generators answer one cycle after gen_en.
                if (valid_dst) begin
                    req_dest_x_d = dest_x;
                    req_dest_y_d = dest_y;
                    req_class_d  = pck_class_in;
                    req_valid_d  = 1'b1;
                    state_d      = S_SEND;
                end else begin
                    pck_number_d = pck_number_q + PCK_ONE;
                    skip_cnt_d   = skip_cnt_q + PCK_ONE;
                    state_d      = S_IDLE;
                end
            end
            S_SEND: begin
                // start is deliberately ignored here: an issued request completes.
                if (req_ready) begin
                    pck_number_d = pck_number_q + PCK_ONE;
                    sent_cnt_d   = sent_cnt_q + PCK_ONE;
                    req_valid_d  = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // done rises the cycle after the last packet is retired.
        done_d = (pck_number_d == PCK_MAX);
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            pck_number_q <= '0;
            sent_cnt_q   <= '0;
            skip_cnt_q   <= '0;
            req_dest_x_q <= '0;
            req_dest_y_q <= '0;
            req_class_q  <= '0;
            req_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            pck_number_q <= pck_number_d;
            sent_cnt_q   <= sent_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            req_dest_x_q <= req_dest_x_d;
            req_dest_y_q <= req_dest_y_d;
            req_class_q  <= req_class_d;
            req_valid_q  <= req_valid_d;
            done_q       <= done_d;
        end
    end

`ifdef TRAFFIC_INJ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_SEND) && !req_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    assign gen_en     = (state_q == S_GEN);
    assign pck_number = pck_number_q;
    assign req_valid  = req_valid_q;
    assign req_dest_x = req_dest_x_q;
    assign req_dest_y = req_dest_y_q;
    assign req_class  = req_class_q;
    assign sent_cnt   = sent_cnt_q;
    assign skip_cnt   = skip_cnt_q;
    assign done       = done_q;

endmodule

// File: tb/tb_traffic_inject_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_inject_ctrl
//
// Two instances: u_dut (INJ_RATE=20, 40 packets) carries the randomized run
// and the directed stall / start-drop / reset scenarios; u_fast
// (INJ_RATE=100, 3 packets) pins the saturated 4-cycle packet period and the
// done timing. The bench plays the generators: on gen_en it drives a fresh
// random destination/class/valid for the following cycle and pushes every
// valid packet into a scoreboard queue; a negedge monitor compares each
// presented request against the queue head.
// ---------------------------------------------------------------------------
module tb_traffic_inject_ctrl;

    localparam int NX = 4, NY = 4, C = 4;
    localparam int MAX_PCK = 40, RATE = 20;
    localparam int F_MAX = 3, F_RATE = 100;
    localparam int XW = 2, YW = 2, CW = 2, NCW = 4;
    localparam int PW = $clog2(MAX_PCK + 1);
    localparam int PWF = $clog2(F_MAX + 1);
`ifdef TRAFFIC_INJ_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pkt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic           reset, start, req_ready;
    logic [XW-1:0]  dest_x;
    logic [YW-1:0]  dest_y;
    logic [CW-1:0]  pck_class_in;
    logic           valid_dst;
    logic           gen_en, req_valid, done;
    logic [PW-1:0]  pck_number, sent_cnt, skip_cnt;
    logic [XW-1:0]  req_dest_x;
    logic [YW-1:0]  req_dest_y;
    logic [CW-1:0]  req_class;
    logic [31:0]    stall_cnt;

    // saturated-rate instance
    logic           reset_f, start_f;
    logic           req_ready_f = 1'b1;
    logic           valid_dst_f = 1'b1;
    logic [XW-1:0]  dest_x_f = '0;
    logic [YW-1:0]  dest_y_f = '0;
    logic [CW-1:0]  class_f = '0;
    logic           gen_en_f, req_valid_f, done_f;
    logic [PWF-1:0] pck_number_f, sent_cnt_f, skip_cnt_f;
    logic [XW-1:0]  req_dest_x_f;
    logic [YW-1:0]  req_dest_y_f;
    logic [CW-1:0]  req_class_f;
    logic [31:0]    stall_cnt_f;

    traffic_inject_ctrl #(.NX(NX), .NY(NY), .C(C), .MAX_PCK_NUM(MAX_PCK), .INJ_RATE(RATE)) u_dut (
        .clk(clk), .reset(reset), .start(start), .core_num(NCW'(5)),
        .gen_en(gen_en), .pck_number(pck_number),
        .dest_x(dest_x), .dest_y(dest_y), .valid_dst(valid_dst), .pck_class_in(pck_class_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_class(req_class),
        .sent_cnt(sent_cnt), .skip_cnt(skip_cnt), .stall_cnt(stall_cnt), .done(done)
    );

    traffic_inject_ctrl #(.NX(NX), .NY(NY), .C(C), .MAX_PCK_NUM(F_MAX), .INJ_RATE(F_RATE)) u_fast (
        .clk(clk), .reset(reset_f), .start(start_f), .core_num(NCW'(0)),
        .gen_en(gen_en_f), .pck_number(pck_number_f),
        .dest_x(dest_x_f), .dest_y(dest_y_f), .valid_dst(valid_dst_f), .pck_class_in(class_f),
        .req_valid(req_valid_f), .req_ready(req_ready_f),
        .req_dest_x(req_dest_x_f), .req_dest_y(req_dest_y_f), .req_class(req_class_f),
        .sent_cnt(sent_cnt_f), .skip_cnt(skip_cnt_f), .stall_cnt(stall_cnt_f), .done(done_f)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Cycle of the k-th gen_en pulse (cycle 0 = first cycle with start=1),
    // with start, valid_dst and req_ready all held high: credit for packet i
    // completes after ceil(100*(i+1)/rate) cycles, IDLE spends one more
    // cycle deciding, and a packet occupies at least 4 cycles.
    function automatic int exp_gen(input int k, input int rate);
        int g = -100;
        for (int i = 0; i <= k; i++) begin
            int a = (100 * (i + 1) + rate - 1) / rate + 1;
            g = (a > g + 4) ? a : g + 4;
        end
        return g;
    endfunction

    // reference model / scoreboard state
    pkt_t sb_q[$];
    int   sent_exp = 0, skip_exp = 0, stall_exp = 0;
    int   gen_seen = 0;
    int   pace_k = 0, fast_k = 0;
    bit   pace_on = 1'b0, force_valid = 1'b1, gen_hold = 1'b0, fast_done_seen = 1'b0;
    int   ncnt = 0, cyc_base = 0, cyc = 0;
    pkt_t act_pkt;

    // Generator model + scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        ncnt = ncnt + 1;
        cyc  = ncnt - cyc_base;
        if (reset) begin
            sb_q.delete();
            sent_exp  = 0;
            skip_exp  = 0;
            stall_exp = 0;
            gen_hold  = 1'b0;
            dest_x = '0; dest_y = '0; pck_class_in = '0; valid_dst = 1'b0;
        end else begin
            if (gen_en) begin
                check("gen_pck_number", longint'(pck_number), sent_exp + skip_exp);
                if (pace_on) begin
                    check("gen_cycle", cyc, exp_gen(pace_k, RATE));
                    pace_k = pace_k + 1;
                    if (pace_k == 3) pace_on = 1'b0;
                end
                gen_seen     = gen_seen + 1;
                dest_x       = XW'($urandom);
                dest_y       = YW'($urandom);
                pck_class_in = CW'($urandom);
                valid_dst    = force_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (valid_dst) sb_q.push_back('{x: dest_x, y: dest_y, c: pck_class_in});
                else skip_exp = skip_exp + 1;
                gen_hold = 1'b1;
            end else if (gen_hold) begin
                gen_hold = 1'b0;  // keep values stable through the CHECK cycle
            end else begin
                dest_x       = XW'($urandom);
                dest_y       = YW'($urandom);
                pck_class_in = CW'($urandom);
                valid_dst    = 1'($urandom);
            end

            if (req_valid) begin
                if (sb_q.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    act_pkt = {req_dest_x, req_dest_y, req_class};
                    check("req_pkt", longint'(act_pkt), longint'(sb_q[0]));
                    if (req_ready) begin
                        void'(sb_q.pop_front());
                        sent_exp = sent_exp + 1;
                    end
                end
                if (!req_ready) stall_exp = stall_exp + 1;
            end
        end

        if (!reset_f) begin
            if (gen_en_f) begin
                check("fast_gen_cycle", cyc, (fast_k < F_MAX) ? exp_gen(fast_k, F_RATE) : -1);
                fast_k = fast_k + 1;
            end
            if (done_f && !fast_done_seen) begin
                fast_done_seen = 1'b1;
                // last accept happens 2 cycles after its gen_en; done follows it
                check("fast_done_cycle", cyc, exp_gen(F_MAX - 1, F_RATE) + 3);
                check("fast_sent_cnt", longint'(sent_cnt_f), F_MAX);
                check("fast_skip_cnt", longint'(skip_cnt_f), 0);
                check("fast_pck_number", longint'(pck_number_f), F_MAX);
            end
        end
    end

    task automatic wait_req_valid(input string name);
        for (int i = 0; i < 500 && !req_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, longint'(req_valid), 1);
    endtask

    initial begin
        int s0, g0, sd0;
        reset = 1'b1; reset_f = 1'b1;
        start = 1'b0; start_f = 1'b0; req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_valid", longint'(req_valid), 0);
        check("reset_done", longint'(done), 0);
        check("reset_gen_en", longint'(gen_en), 0);
        check("reset_pck_number", longint'(pck_number), 0);

        // Pacing: start, valid_dst and req_ready all high from cycle 0.
        reset = 1'b0; reset_f = 1'b0;
        start = 1'b1; start_f = 1'b1; req_ready = 1'b1;
        pace_on  = 1'b1;
        cyc_base = ncnt + 1;
        for (int i = 0; i < 200 && (pace_k < 3 || !fast_done_seen); i++) @(posedge clk);
        #1;
        check("pace_packets_seen", pace_k, 3);
        check("fast_done_seen", longint'(fast_done_seen), 1);
        force_valid = 1'b0;

        // Stall: req_ready low for 7 SEND cycles, accepted on the 8th.
        req_ready = 1'b0;
        wait_req_valid("stall_req_seen");
        s0 = stall_exp;
        repeat (7) @(posedge clk);
        #1 req_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_cycles_seen", stall_exp - s0, 7);
        check("stall_cnt", longint'(stall_cnt), STALL_EN ? stall_exp : 0);
        check("valid_drops_after_accept", longint'(req_valid), 0);

        // start dropped during SEND: request completes, nothing new starts.
        req_ready = 1'b0;
        wait_req_valid("drop_req_seen");
        start = 1'b0; req_ready = 1'b1;
        g0 = gen_seen; sd0 = sent_exp;
        repeat (20) @(posedge clk);
        #1;
        check("no_gen_while_stopped", gen_seen, g0);
        check("send_completes_after_stop", sent_exp, sd0 + 1);
        check("sent_cnt_after_stop", longint'(sent_cnt), sent_exp);
        start = 1'b1;
        for (int i = 0; i < 100 && gen_seen == g0; i++) @(posedge clk);
        #1;
        check("resume_after_start", longint'(gen_seen > g0), 1);

        // Reset during SEND.
        req_ready = 1'b0;
        wait_req_valid("reset_req_seen");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_req_valid", longint'(req_valid), 0);
        check("midreset_sent_cnt", longint'(sent_cnt), 0);
        check("midreset_skip_cnt", longint'(skip_cnt), 0);
        check("midreset_pck_number", longint'(pck_number), 0);
        check("midreset_stall_cnt", longint'(stall_cnt), 0);
        check("midreset_done", longint'(done), 0);
        check("midreset_gen_en", longint'(gen_en), 0);
        reset = 1'b0;

        // Randomized run to completion.
        for (int i = 0; i < 8000 && !done; i++) begin
            req_ready = ($urandom_range(0, 9) < 6);
            start     = ($urandom_range(0, 19) != 0);
            @(posedge clk);
            #1;
        end
        check("done_reached", longint'(done), 1);
        repeat (3) @(posedge clk);
        #1;
        check("final_sent_cnt", longint'(sent_cnt), sent_exp);
        check("final_skip_cnt", longint'(skip_cnt), skip_exp);
        check("final_pck_number", longint'(pck_number), MAX_PCK);
        check("final_model_total", sent_exp + skip_exp, MAX_PCK);
        check("final_stall_cnt", longint'(stall_cnt), STALL_EN ? stall_exp : 0);
        check("final_scoreboard_empty", sb_q.size(), 0);
        check("final_req_valid", longint'(req_valid), 0);
        check("final_done_held", longint'(done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
